ransac_fma_arbiter: RTL and testbench
=====================================

Name: ransac_fma_arbiter

Overview:
- Shares one fully pipelined fixed-point FMA unit (fixed_t operands, fma_opcode_t, fixed latency, no stall) among N_REQ requesters, e.g. the plane-fit and inlier-distance engines.
- Grants one requester per cycle by round-robin and issues its operation to the FMA.
- Tracks a requester tag through a shift register matched to the FMA latency, so each result goes back to the requester that issued it.
- Caps outstanding operations per requester.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- FMA_LATENCY, 3, cycles from fma_issue to fma_result_valid (>=1).
- MAX_OUTSTANDING, 4, maximum in-flight operations per requester (1..FMA_LATENCY+1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester operation valid.
- req_ready  out  N_REQ  one-hot grant; transfer when req_valid[i] & req_ready[i].
- req_op  in  2*N_REQ  fma_opcode_t per requester, slice i at [2i+1:2i].
- req_a  in  32*N_REQ  fixed_t A per requester.
- req_b  in  32*N_REQ  fixed_t B per requester.
- req_c  in  32*N_REQ  fixed_t C per requester.
- fma_issue  out  1  operation presented to the FMA this cycle.
- fma_op  out  2  opcode to the FMA.
- fma_a  out  32  operand A to the FMA.
- fma_b  out  32  operand B to the FMA.
- fma_c  out  32  operand C to the FMA.
- fma_result_valid  in  1  FMA result strobe.
- fma_result  in  32  FMA result (fixed_t).
- rsp_valid  out  N_REQ  one-hot result strobe. No backpressure; the requester must accept it.
- rsp_data  out  32  result, shared by all requesters.
- busy  out  1  any operation in flight.

Behaviour:
- Eligibility: requester i is eligible when req_valid[i]=1 and outstanding[i] < MAX_OUTSTANDING.
- Arbitration is combinational. Search starts at rr_ptr and wraps modulo N_REQ; the first eligible requester gets req_ready. At most one req_ready bit is high; all are 0 if none is eligible.
- fma_issue = |req_ready. fma_op/a/b/c are combinationally muxed from the granted slice and are 0 when there is no grant.
- rr_ptr resets to 0. On a grant to g it becomes (g+1) mod N_REQ; it holds when there is no grant.
- Tag pipeline: FMA_LATENCY stages of {valid, tag[$clog2(N_REQ)-1:0]}. Stage 0 loads {fma_issue, granted index}; each stage shifts every cycle.
- Result routing: when fma_result_valid=1 and the last stage is valid, register rsp_valid = onehot(tag) and rsp_data = fma_result. Response latency is issue + FMA_LATENCY + 1.
- Error case 1: fma_result_valid=1 with the last stage invalid → result dropped, sticky internal error bit set. The bit is visible to the bench only.
- Error case 2: last stage valid with fma_result_valid=0 → rsp_valid=0, counter not decremented, error bit set.
- outstanding[i] (width $clog2(MAX_OUTSTANDING+1)):
  - +1 on grant to i.
  - −1 when a response to i is routed.
  - Unchanged when both happen in the same cycle.
  - Never exceeds MAX_OUTSTANDING and never underflows.
- busy = any tag stage valid, or any outstanding counter non-zero.
- Reset (async assert, any time):
  - req_ready, rsp_valid, fma_issue, busy = 0.
  - rsp_data = 0; all tag stages invalid; counters and rr_ptr = 0.
  - Results arriving after reset against invalid stages are dropped; nothing is delivered.
- No combinational path from fma_result* to req_ready. req_ready may depend combinationally on req_valid.

Test Plan:
- Single requester 0: op=POS_A_POS_C, a=0x01000000, b=0x02000000, c=0x00800000, FMA model returns 0x02800000 after 3 cycles → rsp_valid=0001, rsp_data=0x02800000 exactly 4 cycles after the grant.
- All 4 requesters valid continuously → grants cycle 0,1,2,3,0,…; each response is routed to its own index, checked by distinct operand values per requester.
- Requester 2 alone, MAX_OUTSTANDING=2, held valid → grants in cycles 0 and 1, stall until its first response, then one grant per response; outstanding[2] never exceeds 2.
- Same-cycle grant and response for requester 1 → outstanding[1] unchanged and further grants are not blocked.
- Assert rst_n=0 with 3 operations in flight, FMA model still emits results → no rsp_valid after reset, busy=0, and the next grant goes to requester 0.
- Spurious fma_result_valid with an empty pipeline → no rsp_valid pulse, error bit set.

Source files
------------

// File: rtl/ransac_fma_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ransac_fma_arbiter
// Purpose  : Round-robin sharing of one fixed-latency pipelined FMA unit among
//            N_REQ requesters. Each issued operation carries a requester tag
//            through a latency-matched shift register so every result returns
//            to its issuer. In-flight operations are capped per requester.
// Revision : 1.0 - initial release
// ============================================================================
module ransac_fma_arbiter #(
    parameter int N_REQ           = 4,
    parameter int FMA_LATENCY     = 3,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [2*N_REQ-1:0]    req_op,
    input  logic [32*N_REQ-1:0]   req_a,
    input  logic [32*N_REQ-1:0]   req_b,
    input  logic [32*N_REQ-1:0]   req_c,
    output logic                  fma_issue,
    output logic [1:0]            fma_op,
    output logic [31:0]           fma_a,
    output logic [31:0]           fma_b,
    output logic [31:0]           fma_c,
    input  logic                  fma_result_valid,
    input  logic [31:0]           fma_result,
    output logic [N_REQ-1:0]      rsp_valid,
    output logic [31:0]           rsp_data,
    output logic                  busy
);

    localparam int TAG_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] c_max_out  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [TAG_W-1:0] c_last_req = TAG_W'(N_REQ - 1);

    logic [TAG_W-1:0]       r_rr_ptr;
    logic [N_REQ-1:0]       w_elig;
    logic [N_REQ-1:0]       w_grant;
    logic [TAG_W-1:0]       w_gnt_idx;
    logic                   w_found;

    logic [FMA_LATENCY-1:0] r_tag_v;
    logic [TAG_W-1:0]       r_tag [FMA_LATENCY];
    logic                   w_last_v;
    logic [TAG_W-1:0]       w_last_tag;
    logic                   w_route;

    logic [CNT_W-1:0]       r_outstanding [N_REQ];
    logic [N_REQ-1:0]       w_dec;
    logic [N_REQ-1:0]       w_cnt_nz;

    logic [N_REQ-1:0]       r_rsp_valid;
    logic [31:0]            r_rsp_data;
    logic                   r_err;
    logic                   w_unused_err;

    // Per-requester eligibility, response-decrement strobe and activity flag.
    // Eligibility is gated by rst_n so no grant appears while reset is held.
    for (genvar i = 0; i < N_REQ; i++) begin : g_req
        assign w_elig[i]   = rst_n & req_valid[i] & (r_outstanding[i] < c_max_out);
        assign w_dec[i]    = w_route & (w_last_tag == TAG_W'(i));
        assign w_cnt_nz[i] = |r_outstanding[i];
    end

    assign w_last_v   = r_tag_v[FMA_LATENCY-1];
    assign w_last_tag = r_tag[FMA_LATENCY-1];
    assign w_route    = fma_result_valid & w_last_v;

    // Round-robin scan starting at r_rr_ptr; first eligible requester wins.
    always_comb begin
        int j;
        w_grant   = '0;
        w_gnt_idx = '0;
        w_found   = 1'b0;
        j         = 0;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(r_rr_ptr) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (!w_found && w_elig[j]) begin
                w_found    = 1'b1;
                w_grant[j] = 1'b1;
                w_gnt_idx  = TAG_W'(j);
            end
        end
    end

    // Operand mux from the granted slice; zero when nothing is granted.
    always_comb begin
        fma_op = '0;
        fma_a  = '0;
        fma_b  = '0;
        fma_c  = '0;
        if (w_found) begin
            fma_op = req_op[int'(w_gnt_idx)*2 +: 2];
            fma_a  = req_a[int'(w_gnt_idx)*32 +: 32];
            fma_b  = req_b[int'(w_gnt_idx)*32 +: 32];
            fma_c  = req_c[int'(w_gnt_idx)*32 +: 32];
        end
    end

    assign req_ready = w_grant;
    assign fma_issue = w_found;

    // Pointer advances to the requester after the one just granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else if (w_found) begin
            r_rr_ptr <= (w_gnt_idx == c_last_req) ? '0 : w_gnt_idx + 1'b1;
        end
    end

    // Tag shift register aligned with the FMA pipeline depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_v <= '0;
            for (int s = 0; s < FMA_LATENCY; s++) r_tag[s] <= '0;
        end else begin
            r_tag_v[0] <= w_found;
            r_tag[0]   <= w_gnt_idx;
            for (int s = 1; s < FMA_LATENCY; s++) begin
                r_tag_v[s] <= r_tag_v[s-1];
                r_tag[s]   <= r_tag[s-1];
            end
        end
    end

    // Route results to the tagged requester; flag any result/tag disagreement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_err       <= 1'b0;
        end else begin
            r_rsp_valid <= '0;
            if (w_route) begin
                r_rsp_valid[w_last_tag] <= 1'b1;
                r_rsp_data              <= fma_result;
            end
            if (fma_result_valid != w_last_v) r_err <= 1'b1;
        end
    end

    // Outstanding counters: grant increments, routed response decrements.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_REQ; i++) r_outstanding[i] <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (w_grant[i] && !w_dec[i]) begin
                    r_outstanding[i] <= r_outstanding[i] + 1'b1;
                end else if (w_dec[i] && !w_grant[i] && (r_outstanding[i] != '0)) begin
                    r_outstanding[i] <= r_outstanding[i] - 1'b1;
                end
            end
        end
    end

    // The sticky error bit is an observation point only; nothing consumes it.
    assign w_unused_err = r_err;

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign busy      = (|r_tag_v) | (|w_cnt_nz);

endmodule
`default_nettype wire

// File: tb/tb_ransac_fma_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_ransac_fma_arbiter
// Purpose  : Directed self-checking bench for ransac_fma_arbiter with a
//            3-cycle Q8.24 FMA behavioural model and a cap of 2 in flight.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ransac_fma_arbiter;

    localparam int N    = 4;
    localparam int LAT  = 3;
    localparam int MAXO = 2;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [2*N-1:0]  req_op;
    logic [32*N-1:0] req_a;
    logic [32*N-1:0] req_b;
    logic [32*N-1:0] req_c;
    logic          fma_issue;
    logic [1:0]    fma_op;
    logic [31:0]   fma_a;
    logic [31:0]   fma_b;
    logic [31:0]   fma_c;
    logic          fma_result_valid;
    logic [31:0]   fma_result;
    logic [N-1:0]  rsp_valid;
    logic [31:0]   rsp_data;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    // Behavioural FMA pipeline state (not reset by rst_n)
    logic [2:0]  m_v  = '0;
    logic [31:0] m_r0 = '0;
    logic [31:0] m_r1 = '0;
    logic [31:0] m_r2 = '0;
    logic        inj;

    // Hand-computed expectations
    logic [31:0] exp_all [4] = '{32'h0100_0000, 32'h0210_0000, 32'h0320_0000, 32'h0430_0000};
    int          cnt_exp [15] = '{0, 1, 2, 2, 1, 1, 2, 2, 1, 1, 2, 2, 1, 0, 0};

    ransac_fma_arbiter #(
        .N_REQ          (N),
        .FMA_LATENCY    (LAT),
        .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_op          (req_op),
        .req_a           (req_a),
        .req_b           (req_b),
        .req_c           (req_c),
        .fma_issue       (fma_issue),
        .fma_op          (fma_op),
        .fma_a           (fma_a),
        .fma_b           (fma_b),
        .fma_c           (fma_c),
        .fma_result_valid(fma_result_valid),
        .fma_result      (fma_result),
        .rsp_valid       (rsp_valid),
        .rsp_data        (rsp_data),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Q8.24 multiply-add; opcode selects the signs of product and addend.
    function automatic logic [31:0] fma_calc(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] c);
        logic signed [63:0] p;
        logic [31:0]        pr;
        p  = 64'($signed(a)) * 64'($signed(b));
        pr = p[55:24];
        case (op)
            2'd0:    return pr + c;
            2'd1:    return pr - c;
            2'd2:    return c - pr;
            default: return 32'd0 - pr - c;
        endcase
    endfunction

    // Three-stage FMA model: result appears LAT cycles after issue.
    always @(posedge clk) begin
        m_v  <= {m_v[1:0], fma_issue};
        m_r0 <= fma_calc(fma_op, fma_a, fma_b, fma_c);
        m_r1 <= m_r0;
        m_r2 <= m_r1;
    end

    assign fma_result_valid = m_v[2] | inj;
    assign fma_result       = m_r2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic do_reset();
        req_valid = '0;
        rst_n     = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Single requester held valid against a cap of 2 in flight.
    task automatic run_cap(input int r);
        logic [14:0] gmask;
        logic [14:0] rmask;
        logic [3:0]  oh;
        gmask = 15'h0333;
        rmask = 15'h3330;
        oh    = 4'(1 << r);
        do_reset();
        req_op[2*r +: 2]  = 2'd0;
        req_a[32*r +: 32] = 32'h0100_0000;
        req_b[32*r +: 32] = 32'h0200_0000;
        req_c[32*r +: 32] = 32'h0000_0001;
        for (int k = 0; k < 15; k++) begin
            if (k == 0)  req_valid = oh;
            if (k == 10) req_valid = '0;
            smp();
            chk($sformatf("cap%0d_ready_c%0d", r, k), 32'(req_ready), gmask[k] ? 32'(oh) : 32'd0);
            chk($sformatf("cap%0d_cnt_c%0d", r, k), 32'(dut.r_outstanding[r]), 32'(cnt_exp[k]));
            chk($sformatf("cap%0d_rsp_c%0d", r, k), 32'(rsp_valid), rmask[k] ? 32'(oh) : 32'd0);
            if (rmask[k]) chk($sformatf("cap%0d_data_c%0d", r, k), rsp_data, 32'h0200_0001);
            cyc();
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        req_c     = '0;
        inj       = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        smp();
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_issue", 32'(fma_issue), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_rspv",  32'(rsp_valid), 32'd0);
        chk("rst_rspd",  rsp_data, 32'd0);
        chk("rst_err",   32'(dut.r_err), 32'd0);
        cyc();
        rst_n = 1'b1;

        // Spurious result with nothing in flight
        inj = 1'b1;
        smp();
        chk("spur_rspv0", 32'(rsp_valid), 32'd0);
        cyc();
        inj = 1'b0;
        smp();
        chk("spur_rspv1", 32'(rsp_valid), 32'd0);
        chk("spur_err",   32'(dut.r_err), 32'd1);
        chk("spur_busy",  32'(busy), 32'd0);
        cyc();

        // Single operation from requester 0
        req_valid     = 4'b0001;
        req_op[1:0]   = 2'd0;
        req_a[31:0]   = 32'h0100_0000;
        req_b[31:0]   = 32'h0200_0000;
        req_c[31:0]   = 32'h0080_0000;
        smp();
        chk("one_ready", 32'(req_ready), 32'h1);
        chk("one_issue", 32'(fma_issue), 32'd1);
        chk("one_fma_a", fma_a, 32'h0100_0000);
        chk("one_fma_b", fma_b, 32'h0200_0000);
        chk("one_fma_c", fma_c, 32'h0080_0000);
        cyc();
        req_valid = '0;
        for (int k = 1; k <= 5; k++) begin
            smp();
            if (k == 1) chk("one_busy", 32'(busy), 32'd1);
            if (k == 4) begin
                chk("one_rspv", 32'(rsp_valid), 32'h1);
                chk("one_rspd", rsp_data, 32'h0280_0000);
            end else begin
                chk($sformatf("one_norsp_c%0d", k), 32'(rsp_valid), 32'd0);
            end
            cyc();
        end
        smp();
        chk("one_idle", 32'(busy), 32'd0);
        cyc();

        // All four requesters continuously valid
        do_reset();
        for (int i = 0; i < N; i++) begin
            req_op[2*i +: 2]  = 2'd0;
            req_a[32*i +: 32] = 32'h0100_0000;
            req_b[32*i +: 32] = 32'((i + 1) << 24);
            req_c[32*i +: 32] = 32'(i << 20);
        end
        for (int k = 0; k < 12; k++) begin
            if (k == 0) req_valid = 4'hF;
            if (k == 8) req_valid = '0;
            smp();
            chk($sformatf("rr_ready_c%0d", k), 32'(req_ready), (k < 8) ? 32'(1 << (k % 4)) : 32'd0);
            if (k >= 4) begin
                chk($sformatf("rr_rspv_c%0d", k), 32'(rsp_valid), 32'(1 << ((k - 4) % 4)));
                chk($sformatf("rr_rspd_c%0d", k), rsp_data, exp_all[(k - 4) % 4]);
            end else begin
                chk($sformatf("rr_norsp_c%0d", k), 32'(rsp_valid), 32'd0);
            end
            cyc();
        end

        // Outstanding cap on requester 2, then same-cycle grant+response on 1
        run_cap(2);
        run_cap(1);

        // Reset with three operations in flight
        do_reset();
        for (int k = 0; k < 3; k++) begin
            if (k == 0) req_valid = 4'hF;
            smp();
            chk($sformatf("fl_ready_c%0d", k), 32'(req_ready), 32'(1 << k));
            cyc();
        end
        req_valid = '0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("fl_rst_busy",  32'(busy), 32'd0);
        chk("fl_rst_ready", 32'(req_ready), 32'd0);
        chk("fl_rst_issue", 32'(fma_issue), 32'd0);
        chk("fl_rst_rspd",  rsp_data, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 5; k < 10; k++) begin
            smp();
            chk($sformatf("fl_norsp_c%0d", k), 32'(rsp_valid), 32'd0);
            chk($sformatf("fl_busy_c%0d", k),  32'(busy), 32'd0);
            cyc();
        end
        chk("fl_err", 32'(dut.r_err), 32'd1);
        req_valid = 4'hF;
        smp();
        chk("fl_next_ready", 32'(req_ready), 32'h1);
        chk("fl_next_issue", 32'(fma_issue), 32'd1);
        cyc();
        req_valid = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
